// File: rtl/gray_code_counter.sv
// gray_code_counter: registered up/down Gray counter with load, wrap/saturate and terminal count
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] G,
  output logic             g_valid,
  output logic             tc
);
  logic [WIDTH-1:0] bin, nxt, lb;
  logic step;
  always_comb begin
    lb = '0;
    for (int i = 0; i < WIDTH; i++) lb[i] = ^(load_g >> i);
    tc = up ? (&bin) : ~(|bin);
    nxt = up ? bin + 1'b1 : bin - 1'b1;
    step = en && (WRAP || !tc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      G <= '0;
      g_valid <= 1'b0;
    end else if (load) begin
      bin <= lb;
      G <= load_g;
      g_valid <= 1'b1;
    end else if (step) begin
      bin <= nxt;
      G <= nxt ^ (nxt >> 1);
      g_valid <= 1'b1;
    end else begin
      g_valid <= 1'b0;
    end
  end
endmodule
